fir_dac_tx: RTL and testbench
=============================

Name: fir_dac_tx

Overview:
Output-side companion to the team's 51-tap FIR filters. It takes the filter's wide signed result once per sample, then rounds, scales and saturates it to DAC word width. The word goes into a one-entry holding register and is shifted out as an SPI mode-0 write frame to an external DAC. It sits between the FIR output register and the board DAC pins (Artix-7, clk 100 MHz, Fs 1 MHz).

Parameters:
IN_WIDTH, 39, width of signed filter result (DATA_WIDTH+COEFF_WIDTH+7)
OUT_WIDTH, 16, DAC data bits
GAIN_SHIFT, 0, arithmetic right shift applied before saturation (0..8)
CMD_WIDTH, 8, command bits prepended to each frame
CMD_CODE, 8'h30, command value (write-and-update)
OFFSET_BINARY, 0, 1 = invert data MSB (two's complement to offset binary)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
GAP_CYCLES, 2, cs_n high time between frames, in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  one-cycle strobe: in_data holds a new filter sample
in_data  in  IN_WIDTH  signed filter result
in_ready  out  1  holding register empty (advisory; in_valid is always accepted)
clr_flags  in  1  clears sat_sticky
dac_cs_n  out  1  DAC chip select, active low
dac_sclk  out  1  serial clock, idles low
dac_sdata  out  1  serial data, MSB first
busy  out  1  frame in progress (cs_n low or in gap)
frame_done  out  1  one-cycle pulse at end of gap
overrun  out  1  one-cycle pulse when an unsent pending word is overwritten
sat_sticky  out  1  set when any sample saturated

Behaviour:
- Reset (rst synchronous, active-high; clock clk): dac_cs_n=1, dac_sclk=0, dac_sdata=0, busy=0, frame_done=0, overrun=0, sat_sticky=0, in_ready=1. Holding register is cleared. FSM goes to IDLE. Reset mid-frame aborts the frame on the next edge with no partial completion.
- Quantise, 1-cycle registered, on in_valid:
  - t = (in_data + 2^(GAIN_SHIFT-1)) >>> GAIN_SHIFT, round half up. For GAIN_SHIFT=0, t = in_data.
  - Compute t at IN_WIDTH+1 bits so the rounding add cannot wrap.
  - Saturate t to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - On saturation set sat_sticky. Set wins over a same-cycle clr_flags.
  - Apply the OFFSET_BINARY MSB flip after saturation.
- Holding register:
  - The quantised word is written one cycle after in_valid.
  - If the register is already full, the new word overwrites it and overrun pulses in that cycle.
  - If the FSM loads in the same cycle as a write, the load takes the old word and the register holds the new one; no overrun.
- FSM states IDLE, SETUP, SHIFT, GAP.
  - IDLE: cs_n=1. If the holding register is full, load shift reg = {CMD_CODE, word}. FRAME_BITS = CMD_WIDTH+OUT_WIDTH. Clear the register and go to SETUP.
  - SETUP: cs_n=0, sdata=frame MSB, sclk=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: sclk toggles every CLK_DIV cycles. The DAC samples on rising edges. sdata advances to the next bit on each falling edge. After the FRAME_BITS-th rising edge, hold sclk high CLK_DIV cycles, then drive sclk low and cs_n high together and go to GAP.
  - GAP: cs_n=1 for GAP_CYCLES, pulse frame_done on the last cycle, return to IDLE. If a word is pending, the next frame starts the following cycle.
- busy=1 in SETUP, SHIFT and GAP.
- Frame length = CLK_DIV*(1+2*FRAME_BITS)+GAP_CYCLES clk cycles. With defaults that is 100, which exactly meets 100 MHz/1 MHz. Integration must keep the sample period at or above this; otherwise overrun pulses.
- Bit/edge counters count down and wrap to reload values; no free-running state carries across frames.

Decomposition:
- Package fir_dac_pkg: FSM state enum; default CMD_CODE; function sat_round(value, shift, out_width) returning {word, sat_flag}; frame-length constant function for use by benches.
- Sub-module fir_out_quantizer: registered round/saturate/offset stage with valid out.
- Top fir_dac_tx holds the holding register, the FSM and the serializer.

Test Plan:
- in_data=1000, GAIN_SHIFT=0 -> frame 0x3003E8 captured on sclk rising edges; cs_n low for 98 cycles; frame_done pulse on cycle 100 after load.
- in_data=40000 -> data 0x7FFF, sat_sticky=1. in_data=-40000 -> 0x8000. clr_flags -> sat_sticky=0. With OFFSET_BINARY=1, -40000 -> 0x0000.
- GAIN_SHIFT=1: in_data=3 -> 2; in_data=-3 -> -1 (0xFFFF); in_data=-4 -> -2 (0xFFFE).
- Samples A, B, C at cycles 0, 10, 20 -> A frame sent, C overwrites B, overrun pulses once (cycle 21), next frame carries C, B never appears.
- Back-to-back samples every 100 cycles for 50 samples -> no overrun, 50 frames, each word matches its sat_round reference.
- rst asserted at the 10th sclk rising edge -> next cycle cs_n=1, sclk=0, sdata=0, busy=0, in_ready=1; no frame_done; a sample arriving after reset is sent as a complete frame.

Source files
------------

// File: rtl/fir_dac_pkg.sv
// Shared types and helpers for the FIR-to-DAC output path: FSM states,
// default DAC command, round/saturate reference and frame-length helper.
package fir_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } dac_state_t;

  localparam logic [7:0]  DEF_CMD_CODE = 8'h30;
  localparam int unsigned SAT_CALC_W   = 64;
  localparam int unsigned SAT_WORD_W   = 32;

  // Round-half-up arithmetic shift then saturate; returns {word, sat_flag}.
  // value must already be sign-extended to SAT_CALC_W, so the rounding add cannot wrap.
  function automatic logic [SAT_WORD_W:0] sat_round(
    input logic signed [SAT_CALC_W-1:0] value,
    input int unsigned                  shift,
    input int unsigned                  out_width
  );
    logic signed [SAT_CALC_W-1:0] t;
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    logic [SAT_WORD_W-1:0]        w;
    logic [SAT_WORD_W-1:0]        mask;
    logic                         sat;
    t = value;
    if (shift != 0) begin
      t = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_width - 1));
    sat = 1'b1;
    if (t > hi) begin
      w = hi[SAT_WORD_W-1:0];
    end else if (t < lo) begin
      w = lo[SAT_WORD_W-1:0];
    end else begin
      w   = t[SAT_WORD_W-1:0];
      sat = 1'b0;
    end
    mask = (out_width >= SAT_WORD_W) ? '1 : ((32'd1 << out_width) - 32'd1);
    return {w & mask, sat};
  endfunction

  // Total clk cycles from frame load to the end of the inter-frame gap.
  function automatic int unsigned frame_cycles(
    input int unsigned clk_div,
    input int unsigned frame_bits,
    input int unsigned gap_cycles
  );
    return clk_div * (1 + 2 * frame_bits) + gap_cycles;
  endfunction

endpackage

// File: rtl/fir_out_quantizer.sv
// Registered round / saturate / offset-binary stage between the FIR result
// and the DAC word, with a sticky saturation flag.
module fir_out_quantizer
  import fir_dac_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 39,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int unsigned GAIN_SHIFT    = 0,
  parameter bit          OFFSET_BINARY = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        clr_flags,
  output logic                        q_valid,
  output logic        [OUT_WIDTH-1:0] q_word,
  output logic                        sat_sticky
);

  logic signed [SAT_CALC_W-1:0] ext_c;
  logic        [SAT_WORD_W:0]   res_c;
  logic        [OUT_WIDTH-1:0]  word_c;
  logic                         sat_c;
  logic                         unused_res_c;

  always_comb begin
    ext_c        = {{(SAT_CALC_W - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    res_c        = sat_round(ext_c, GAIN_SHIFT, OUT_WIDTH);
    word_c       = res_c[OUT_WIDTH:1];
    sat_c        = res_c[0];
    unused_res_c = ^res_c;
    if (OFFSET_BINARY) begin
      word_c[OUT_WIDTH-1] = ~word_c[OUT_WIDTH-1];
    end
  end

  // A saturating sample sets the flag even if clr_flags arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid    <= 1'b0;
      q_word     <= '0;
      sat_sticky <= 1'b0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) begin
        q_word <= word_c;
      end
      if (in_valid && sat_c) begin
        sat_sticky <= 1'b1;
      end else if (clr_flags) begin
        sat_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_dac_tx.sv
// FIR output to SPI mode-0 DAC transmitter: quantiser, one-entry holding
// register, and frame FSM/serializer ({CMD_CODE, word}, MSB first).
module fir_dac_tx
  import fir_dac_pkg::*;
#(
  parameter int unsigned           IN_WIDTH      = 39,
  parameter int unsigned           OUT_WIDTH     = 16,
  parameter int unsigned           GAIN_SHIFT    = 0,
  parameter int unsigned           CMD_WIDTH     = 8,
  parameter logic [CMD_WIDTH-1:0]  CMD_CODE      = CMD_WIDTH'(DEF_CMD_CODE),
  parameter bit                    OFFSET_BINARY = 1'b0,
  parameter int unsigned           CLK_DIV       = 2,
  parameter int unsigned           GAP_CYCLES    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       in_ready,
  input  logic                       clr_flags,
  output logic                       dac_cs_n,
  output logic                       dac_sclk,
  output logic                       dac_sdata,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       sat_sticky
);

  localparam int unsigned FRAME_BITS = CMD_WIDTH + OUT_WIDTH;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  logic                  q_valid;
  logic [OUT_WIDTH-1:0]  q_word;

  fir_out_quantizer #(
    .IN_WIDTH      (IN_WIDTH),
    .OUT_WIDTH     (OUT_WIDTH),
    .GAIN_SHIFT    (GAIN_SHIFT),
    .OFFSET_BINARY (OFFSET_BINARY)
  ) u_quant (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr_flags  (clr_flags),
    .q_valid    (q_valid),
    .q_word     (q_word),
    .sat_sticky (sat_sticky)
  );

  dac_state_t            state, state_nxt;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                  cs_n_nxt, sclk_nxt, sdata_nxt, busy_nxt, done_nxt;

  logic                  hold_full, hold_full_nxt;
  logic [OUT_WIDTH-1:0]  hold_word;
  logic                  load_c;
  logic [FRAME_BITS-1:0] frame_c;

  assign load_c  = (state == ST_IDLE) && hold_full;
  assign frame_c = {CMD_CODE, hold_word};

  // A load in the same cycle as a write takes the old word; the new one stays pending.
  always_comb begin
    hold_full_nxt = q_valid | (hold_full & ~load_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_word <= '0;
      in_ready  <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      if (q_valid) begin
        hold_word <= q_word;
      end
      in_ready <= ~hold_full_nxt;
      overrun  <= q_valid & hold_full & ~load_c;
    end
  end

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    shreg_nxt = shreg;
    cs_n_nxt  = dac_cs_n;
    sclk_nxt  = dac_sclk;
    sdata_nxt = dac_sdata;
    unique case (state)
      ST_IDLE: begin
        if (hold_full) begin
          shreg_nxt = frame_c;
          sdata_nxt = frame_c[FRAME_BITS-1];
          cs_n_nxt  = 1'b0;
          sclk_nxt  = 1'b0;
          div_nxt   = DIV_RELOAD;
          bit_nxt   = BIT_RELOAD;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_cnt == '0) begin
          div_nxt   = DIV_RELOAD;
          bit_nxt   = BIT_RELOAD;
          state_nxt = ST_SHIFT;
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_cnt == '0) begin
          div_nxt = DIV_RELOAD;
          if (!dac_sclk) begin
            sclk_nxt = 1'b1;
          end else if (bit_cnt == '0) begin
            // Last bit's high phase is over: release the bus in one step.
            sclk_nxt  = 1'b0;
            cs_n_nxt  = 1'b1;
            sdata_nxt = 1'b0;
            gap_nxt   = GAP_RELOAD;
            state_nxt = ST_GAP;
          end else begin
            sclk_nxt  = 1'b0;
            shreg_nxt = shreg << 1;
            sdata_nxt = shreg[FRAME_BITS-2];
            bit_nxt   = bit_cnt - BIT_W'(1);
          end
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        sdata_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_GAP) && (gap_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_sdata  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      gap_cnt    <= gap_nxt;
      shreg      <= shreg_nxt;
      dac_cs_n   <= cs_n_nxt;
      dac_sclk   <= sclk_nxt;
      dac_sdata  <= sdata_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fir_dac_tx.sv
// Bench for fir_dac_tx: three instances (default, GAIN_SHIFT=1, OFFSET_BINARY=1)
// share one stimulus; SPI frames are captured and compared to an arithmetic model.
module tb_fir_dac_tx;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [38:0] in_data = '0;
  logic               clr_flags = 1'b0;
  logic [2:0] cs_n, sclk, sdata, busy, frame_done, overrun, sat_sticky, in_ready;

  always #5 clk = ~clk;

  fir_dac_tx #(.GAIN_SHIFT(0), .OFFSET_BINARY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .clr_flags(clr_flags), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_sdata(sdata[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0]), .sat_sticky(sat_sticky[0]));
  fir_dac_tx #(.GAIN_SHIFT(1), .OFFSET_BINARY(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .clr_flags(clr_flags), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_sdata(sdata[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1]), .sat_sticky(sat_sticky[1]));
  fir_dac_tx #(.GAIN_SHIFT(0), .OFFSET_BINARY(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[2]),
    .clr_flags(clr_flags), .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_sdata(sdata[2]),
    .busy(busy[2]), .frame_done(frame_done[2]), .overrun(overrun[2]), .sat_sticky(sat_sticky[2]));

  int total = 0;
  int bad   = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI capture: record = {bit count, last 24 bits seen on sclk rising edges}
  logic [31:0] fq0[$], fq1[$], fq2[$];
  logic [2:0]  pcs = 3'b111, psclk = 3'b000;
  logic [23:0] shr [3];
  int          nbv [3];
  int          fdc [3];
  int          ovc [3];
  longint      ov_cyc = 0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      shr[i] = '0; nbv[i] = 0; fdc[i] = 0; ovc[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cs_n[i] === 1'b0 && pcs[i]) begin
        shr[i] = '0;
        nbv[i] = 0;
      end
      if (cs_n[i] === 1'b0 && sclk[i] === 1'b1 && !psclk[i]) begin
        shr[i] = {shr[i][22:0], sdata[i]};
        nbv[i] = nbv[i] + 1;
      end
      if (cs_n[i] === 1'b1 && !pcs[i]) begin
        case (i)
          0: fq0.push_back({8'(nbv[i]), shr[i]});
          1: fq1.push_back({8'(nbv[i]), shr[i]});
          default: fq2.push_back({8'(nbv[i]), shr[i]});
        endcase
      end
      if (frame_done[i] === 1'b1) fdc[i] = fdc[i] + 1;
      if (overrun[i] === 1'b1) begin
        ovc[i] = ovc[i] + 1;
        if (i == 0) ov_cyc = cyc;
      end
    end
    pcs   = cs_n;
    psclk = sclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((v + 2^(sh-1)) / 2^sh), clamp to 16-bit signed, optional MSB flip.
  function automatic logic [16:0] ref_q(input longint v, input int sh, input bit ob);
    longint d, n, t;
    logic [15:0] w;
    bit s;
    d = 1;
    for (int k = 0; k < sh; k++) d = d * 2;
    n = v + d / 2;
    t = n / d;
    if ((n % d) != 0 && n < 0) t = t - 1;
    s = 1'b0;
    if (t > 32767) begin t = 32767; s = 1'b1; end
    else if (t < -32768) begin t = -32768; s = 1'b1; end
    w = 16'(t);
    if (ob) w[15] = ~w[15];
    return {s, w};
  endfunction

  bit [2:0] sticky_exp = 3'b000;

  task automatic pop_frame(input int i, output logic [31:0] r);
    r = '0;
    case (i)
      0: if (fq0.size() > 0) r = fq0.pop_front();
      1: if (fq1.size() > 0) r = fq1.pop_front();
      default: if (fq2.size() > 0) r = fq2.pop_front();
    endcase
  endtask

  task automatic exp_all(input longint v, input string tag);
    logic [16:0] m;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      m = ref_q(v, (i == 1) ? 1 : 0, i == 2);
      pop_frame(i, r);
      chk($sformatf("%s_frame%0d", tag, i), 64'(r), 64'({8'd24, 8'h30, m[15:0]}));
      if (m[16]) sticky_exp[i] = 1'b1;
    end
  endtask

  task automatic send(input longint v);
    in_valid = 1'b1;
    in_data  = 39'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(busy == 3'b000 && in_ready == 3'b111) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_idle_timeout"}, 64'(n < 2000), 64'd1);
  endtask

  initial begin
    int n, low, k, fd0, ov0, fdb;
    longint base;
    longint vals[$];
    logic [31:0] r;
    logic signed [38:0] rd;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs%0d", i),
          64'({cs_n[i], sclk[i], sdata[i], busy[i], frame_done[i], overrun[i], sat_sticky[i], in_ready[i]}),
          64'(8'b1000_0001));
    rst = 1'b0;
    @(negedge clk);

    // Basic frame and its timing on the default instance
    send(1000);
    n = 0;
    while (cs_n[0] && n < 20) begin @(negedge clk); n++; end
    chk("cs_fall_latency", 64'(n), 64'd2);
    low = 0;
    while (!cs_n[0] && low < 300) begin low++; @(negedge clk); end
    chk("cs_low_cycles", 64'(low), 64'd98);
    k = 0;
    while (!frame_done[0] && k < 10) begin k++; @(negedge clk); end
    chk("frame_done_cycle", 64'(low + k + 1), 64'd100);
    wait_idle("t1");
    exp_all(1000, "d1000");

    send(40000);
    wait_idle("t2");
    exp_all(40000, "pos_sat");
    for (int i = 0; i < 3; i++) chk($sformatf("sticky_pos%0d", i), 64'(sat_sticky[i]), 64'(sticky_exp[i]));
    send(-40000);
    wait_idle("t3");
    exp_all(-40000, "neg_sat");
    for (int i = 0; i < 3; i++) chk($sformatf("sticky_neg%0d", i), 64'(sat_sticky[i]), 64'(sticky_exp[i]));
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    sticky_exp = 3'b000;
    chk("sticky_clear", 64'(sat_sticky), 64'd0);

    // Rounding corners, most visible on the GAIN_SHIFT=1 instance
    send(3);  wait_idle("r3");  exp_all(3, "rnd_p3");
    send(-3); wait_idle("rm3"); exp_all(-3, "rnd_m3");
    send(-4); wait_idle("rm4"); exp_all(-4, "rnd_m4");
    chk("sticky_after_rnd", 64'(sat_sticky), 64'(sticky_exp));

    // A, B, C ten cycles apart: C overwrites B
    ov0 = ovc[0];
    base = cyc + 1;
    for (int j = 0; j <= 25; j++) begin
      in_valid = (j == 0 || j == 10 || j == 20);
      in_data  = (j == 0) ? 39'sd1111 : (j == 10) ? 39'sd2222 : 39'sd3333;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle("ovr");
    chk("overrun_count", 64'(ovc[0] - ov0), 64'd1);
    chk("overrun_cycle", 64'(ov_cyc - base), 64'd21);
    exp_all(1111, "ovr_a");
    exp_all(3333, "ovr_c");
    chk("ovr_b_absent", 64'(fq0.size()), 64'd0);

    // 50 random samples at the 100-cycle sample period
    fdb = fdc[0];
    ov0 = ovc[0];
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd = 39'({$urandom, $urandom});
        vals.push_back(longint'(rd));
      end else begin
        vals.push_back(longint'($urandom_range(0, 100000)) - 50000);
      end
      send(vals[s]);
      repeat (99) @(negedge clk);
    end
    wait_idle("rand");
    chk("rand_frame_count", 64'(fdc[0] - fdb), 64'd50);
    chk("rand_no_overrun", 64'(ovc[0] - ov0), 64'd0);
    for (int s = 0; s < 50; s++) exp_all(vals[s], $sformatf("rand%0d", s));
    chk("rand_sticky", 64'(sat_sticky), 64'(sticky_exp));

    // Reset during the 10th sclk rising edge of a frame
    send(1234);
    n = 0;
    while (nbv[0] != 10 && n < 300) begin @(negedge clk); n++; end
    chk("rst_wait_rise10", 64'(n < 300), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sticky_exp = 3'b000;
    for (int i = 0; i < 3; i++)
      chk($sformatf("midframe_reset%0d", i),
          64'({cs_n[i], sclk[i], sdata[i], busy[i], frame_done[i], in_ready[i]}), 64'(6'b100001));
    fd0 = fdc[0];
    repeat (150) @(negedge clk);
    chk("rst_no_frame_done", 64'(fdc[0] - fd0), 64'd0);
    chk("rst_one_partial", 64'(fq0.size()), 64'd1);
    pop_frame(0, r);
    chk("rst_partial_bits", 64'(r[31:24]), 64'd10);
    pop_frame(1, r);
    pop_frame(2, r);
    send(-777);
    wait_idle("post_rst");
    exp_all(-777, "post_rst");
    chk("post_rst_done", 64'(fdc[0] - fd0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
